// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD CMD line: token layout, CRC7 polynomial and
// the framer state type. The CMD response receiver reuses this package.
package sd_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } cmd_state_t;

  localparam logic [6:0] CRC7_POLY        = 7'h09;
  localparam int         CMD_FRAME_BITS   = 48;
  localparam int         CMD_PAYLOAD_BITS = 40;
  localparam int         CMD_FRAME_BYTES  = 6;
  localparam logic       START_BIT        = 1'b0;
  localparam logic       TX_BIT           = 1'b1;
  localparam logic       END_BIT          = 1'b1;

  // Byte k of the 48-bit token, MSB-first; byte 5 carries CRC7 and the end bit.
  function automatic logic [7:0] frame_byte(input logic [39:0] frame40,
                                            input logic [6:0]  crc,
                                            input logic [2:0]  idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = frame40[39:32];
      3'd1:    b = frame40[31:24];
      3'd2:    b = frame40[23:16];
      3'd3:    b = frame40[15:8];
      3'd4:    b = frame40[7:0];
      default: b = {crc, END_BIT};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one bit per enabled cycle, MSB of the message first.
// Shared by the command framer and the response-side CRC check.
module sd_crc7
  import sd_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic fb;

  assign fb = din ^ crc[6];

  always_ff @(posedge clk) begin
    if (clr) begin
      crc <= 7'h00;
    end else if (en) begin
      crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sd_cmd_tx_framer.sv
// Builds the 48-bit SD command token (start, tx, index, arg, CRC7, end) and
// hands it byte by byte to the CMD serializer, advancing on its complete strobe.
module sd_cmd_tx_framer
  import sd_cmd_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         sd_clock,
  input  logic         reset,
  input  logic         cmd_start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic         ser_complete,
  output logic [N-1:0] ser_parallel,
  output logic         ser_enable,
  output logic         busy,
  output logic         done
);

  if (N != 8) begin : g_width_check
    $error("sd_cmd_tx_framer: only N = 8 is supported");
  end

  cmd_state_t  state;
  logic [39:0] frame40;
  logic [5:0]  bit_cnt;
  logic [5:0]  bit_pos;
  logic [2:0]  byte_idx;
  logic [6:0]  crc;
  logic        crc_clr;
  logic        crc_en;
  logic        crc_din;

  // CRC register stays cleared while idle so each token starts from zero.
  assign crc_clr = reset || (state == IDLE);
  assign crc_en  = (state == CALC);
  assign bit_pos = 6'd39 - bit_cnt;
  assign crc_din = frame40[bit_pos];

  sd_crc7 u_crc7 (
    .clk (sd_clock),
    .clr (crc_clr),
    .en  (crc_en),
    .din (crc_din),
    .crc (crc)
  );

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state        <= IDLE;
      frame40      <= 40'h0;
      bit_cnt      <= 6'd0;
      byte_idx     <= 3'd0;
      ser_parallel <= '0;
      ser_enable   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (cmd_start) begin
            frame40  <= {START_BIT, TX_BIT, cmd_index, cmd_arg};
            bit_cnt  <= 6'd0;
            byte_idx <= 3'd0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          if (bit_cnt == 6'd39) begin
            byte_idx     <= 3'd0;
            ser_parallel <= frame40[39:32];
            ser_enable   <= 1'b1;
            state        <= SEND;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        SEND: begin
          // The next byte is loaded while the serializer still shifts bit 0.
          if (ser_complete) begin
            if (byte_idx < 3'd5) begin
              byte_idx     <= byte_idx + 3'd1;
              ser_parallel <= frame_byte(frame40, crc, byte_idx + 3'd1);
            end else begin
              ser_enable <= 1'b0;
              done       <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_tx_framer.sv
// Randomized self-checking bench for sd_cmd_tx_framer with a behavioural
// serializer and a polynomial-division CRC7 reference model.
module tb_sd_cmd_tx_framer;

  logic        sd_clock;
  logic        reset;
  logic        cmd_start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        ser_complete;
  logic [7:0]  ser_parallel;
  logic        ser_enable;
  logic        busy;
  logic        done;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [7:0] byte_q[$];
  logic       bit_q[$];
  bit         ser_shifting;
  int         ser_pos;
  logic [7:0] ser_word;

  sd_cmd_tx_framer #(.N(8)) dut (
    .sd_clock     (sd_clock),
    .reset        (reset),
    .cmd_start    (cmd_start),
    .cmd_index    (cmd_index),
    .cmd_arg      (cmd_arg),
    .ser_complete (ser_complete),
    .ser_parallel (ser_parallel),
    .ser_enable   (ser_enable),
    .busy         (busy),
    .done         (done)
  );

  initial sd_clock = 1'b0;
  always #5 sd_clock = ~sd_clock;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks_total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    else
      checks_passed++;
  endtask

  // Token from the rules: payload, remainder of payload*x^7 divided by x^7+x^3+1, end bit.
  function automatic logic [47:0] model_token(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] payload;
    logic [46:0] rem;
    logic [46:0] poly;
    payload = {1'b0, 1'b1, idx, arg};
    rem     = {payload, 7'b0};
    poly    = 47'h89;
    for (int i = 46; i >= 7; i--)
      if (rem[i]) rem = rem ^ (poly << (i - 7));
    return {payload, rem[6:0], 1'b1};
  endfunction

  // Behavioural serializer: loads a word, shifts it MSB-first, raises complete on bit 0,
  // idles a random number of cycles between words and throws spurious strobes while disabled.
  initial begin
    ser_complete = 1'b0;
    ser_shifting = 1'b0;
    ser_pos      = 0;
    ser_word     = 8'h00;
    forever begin
      @(negedge sd_clock);
      if (reset) begin
        ser_shifting = 1'b0;
        ser_complete = 1'b0;
      end else if (ser_shifting) begin
        if (ser_pos == 0) begin
          ser_shifting = 1'b0;
          ser_complete = 1'b0;
        end else begin
          ser_pos--;
          bit_q.push_back(ser_word[ser_pos]);
          ser_complete = (ser_pos == 0);
        end
      end else begin
        ser_complete = 1'b0;
        if (ser_enable) begin
          if ($urandom_range(3) != 0) begin
            ser_word = ser_parallel;
            byte_q.push_back(ser_word);
            ser_pos = 7;
            bit_q.push_back(ser_word[7]);
            ser_shifting = 1'b1;
          end
        end else begin
          ser_complete = ($urandom_range(3) == 0);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [5:0] idx, input logic [31:0] arg,
                               input bit guard, output logic [47:0] stream);
    logic [47:0] exp_tok;
    logic [7:0]  par0;
    int          k, en_cycle, fall_cycle, done_cycle, done_cnt;
    bit          calc_bad, guard_sent;
    exp_tok    = model_token(idx, arg);
    en_cycle   = -1;
    fall_cycle = -1;
    done_cycle = -1;
    done_cnt   = 0;
    calc_bad   = 1'b0;
    guard_sent = 1'b0;
    stream     = 48'h0;
    @(negedge sd_clock);
    byte_q.delete();
    bit_q.delete();
    par0      = ser_parallel;
    cmd_start = 1'b1;
    cmd_index = idx;
    cmd_arg   = arg;
    @(negedge sd_clock);
    cmd_start = 1'b0;
    cmd_index = 6'($urandom);
    cmd_arg   = $urandom;
    checkOutput("busy_rise", {63'b0, busy}, 64'd1);
    k = 0;
    while (k < 1000 && !(done_cycle >= 0 && k > done_cycle + 3)) begin
      if (en_cycle < 0 && ser_enable) en_cycle = k;
      if (en_cycle < 0 && ser_parallel !== par0) calc_bad = 1'b1;
      if (en_cycle >= 0 && fall_cycle < 0 && !ser_enable) fall_cycle = k;
      if (done) begin
        done_cnt++;
        if (done_cycle < 0) begin
          done_cycle = k;
          checkOutput("busy_in_done", {63'b0, busy}, 64'd1);
        end
      end
      if (done_cycle >= 0 && k == done_cycle + 1)
        checkOutput("busy_fall", {63'b0, busy}, 64'd0);
      if (guard && !guard_sent && byte_q.size() == 2) begin
        cmd_start  = 1'b1;
        cmd_index  = 6'd17;
        cmd_arg    = $urandom;
        guard_sent = 1'b1;
      end else begin
        cmd_start = 1'b0;
      end
      @(negedge sd_clock);
      k++;
    end
    cmd_start = 1'b0;
    checkOutput("no_timeout", {63'b0, (done_cycle >= 0)}, 64'd1);
    checkOutput("enable_latency", 64'(en_cycle), 64'd40);
    checkOutput("calc_quiet", {63'b0, calc_bad}, 64'd0);
    checkOutput("done_once", 64'(done_cnt), 64'd1);
    checkOutput("done_after_fall", 64'(done_cycle), 64'(fall_cycle));
    checkOutput("byte_count", 64'(byte_q.size()), 64'd6);
    checkOutput("bit_count", 64'(bit_q.size()), 64'd48);
    for (int i = 0; i < 6 && i < byte_q.size(); i++)
      checkOutput($sformatf("byte%0d", i), {56'b0, byte_q[i]}, {56'b0, exp_tok[47 - 8*i -: 8]});
    for (int i = 0; i < 48 && i < bit_q.size(); i++)
      stream[47 - i] = bit_q[i];
    checkOutput("serial_stream", {16'b0, stream}, {16'b0, exp_tok});
  endtask

  task automatic resetMidOp(input bit in_send, output bit timed_out);
    int waited;
    timed_out = 1'b0;
    @(negedge sd_clock);
    byte_q.delete();
    bit_q.delete();
    cmd_start = 1'b1;
    cmd_index = 6'd0;
    cmd_arg   = $urandom;
    @(negedge sd_clock);
    cmd_start = 1'b0;
    if (!in_send) begin
      repeat ($urandom_range(3, 35)) @(negedge sd_clock);
    end else begin
      waited = 0;
      while (byte_q.size() < 4 && waited < 500) begin
        @(negedge sd_clock);
        waited++;
      end
      timed_out = (waited >= 500);
    end
    reset = 1'b1;
    @(negedge sd_clock);
    checkOutput(in_send ? "reset_in_send" : "reset_in_calc",
                {53'b0, ser_enable, busy, done, ser_parallel}, 64'd0);
    reset = 1'b0;
    repeat (3) @(negedge sd_clock);
    checkOutput("idle_after_reset", {62'b0, ser_enable, busy}, 64'd0);
  endtask

  initial begin
    logic [47:0] stream;
    bit          to;
    reset     = 1'b1;
    cmd_start = 1'b0;
    cmd_index = 6'd0;
    cmd_arg   = 32'h0;
    repeat (3) @(negedge sd_clock);
    checkOutput("reset_state", {53'b0, ser_enable, busy, done, ser_parallel}, 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge sd_clock);

    applyStimulus(6'd0, 32'h0, 1'b0, stream);
    checkOutput("cmd0_token", {16'b0, stream}, 64'h4000_0000_0095);
    applyStimulus(6'd17, 32'h0, 1'b0, stream);
    checkOutput("cmd17_token", {16'b0, stream}, 64'h5100_0000_0055);
    applyStimulus(6'd8, 32'h0000_01AA, 1'b0, stream);
    checkOutput("cmd8_token", {16'b0, stream}, 64'h4800_0001_AA87);
    applyStimulus(6'd0, 32'h0, 1'b1, stream);
    checkOutput("busy_guard_token", {16'b0, stream}, 64'h4000_0000_0095);

    resetMidOp(1'b0, to);
    applyStimulus(6'd0, 32'h0, 1'b0, stream);
    checkOutput("cmd0_after_calc_reset", {16'b0, stream}, 64'h4000_0000_0095);
    resetMidOp(1'b1, to);
    checkOutput("reach_byte3", {63'b0, to}, 64'd0);
    applyStimulus(6'd0, 32'h0, 1'b0, stream);
    checkOutput("cmd0_after_send_reset", {16'b0, stream}, 64'h4000_0000_0095);

    for (int n = 0; n < 8; n++)
      applyStimulus(6'($urandom_range(63)), $urandom, 1'($urandom_range(1)), stream);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
